// File: rtl/job_ctrl_pkg.sv
// Shared definitions for the job controller: state encodings and DONE_MODE values.
package job_ctrl_pkg;

    localparam int STATE_W = 2;

    // DONE_MODE selections
    localparam int DONE_PULSE = 0;
    localparam int DONE_HOLD  = 1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY   = 2'b01,
        ST_FINISH = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

endpackage

// File: rtl/job_len_counter.sv
// Down-counter holding the cycles left in the current job.
// Priority: clear > load > dec; never decrements below zero.
module job_len_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clear,
    output logic [CNT_W-1:0] remaining,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Remaining-cycle register
    always_ff @(posedge clk) begin
        if (clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (dec && (remaining != '0)) begin
            remaining <= remaining - ONE;
        end
    end

    // Final busy cycle of the job
    always_comb begin
        last = (remaining == ONE);
    end

endmodule

// File: rtl/job_ctrl_fsm.sv
// Job controller: start/len launches a job of len cycles, abort ends it early,
// done is either a one-cycle pulse (DONE_PULSE) or held until ack (DONE_HOLD).
// Optional macro JOB_CTRL_STATS_EN adds job_cnt, a saturating count of
// jobs completed without abort.
module job_ctrl_fsm
    import job_ctrl_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int DONE_MODE = DONE_PULSE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state_o
`ifdef JOB_CTRL_STATS_EN
    ,
    output logic [15:0]      job_cnt
`endif
);

    state_t state;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_clear;
    logic   cnt_last;

    // Counter control derived from the current state and inputs
    always_comb begin
        cnt_load  = (state == ST_IDLE) && start && (len != '0);
        cnt_dec   = (state == ST_BUSY) && !abort;
        cnt_clear = rst || ((state == ST_BUSY) && abort) || (state == ST_BAD);
    end

    job_len_counter #(
        .CNT_W (CNT_W)
    ) u_len_counter (
        .clk       (clk),
        .load      (cnt_load),
        .load_val  (len),
        .dec       (cnt_dec),
        .clear     (cnt_clear),
        .remaining (remaining),
        .last      (cnt_last)
    );

    // Controller state and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
`ifdef JOB_CTRL_STATS_EN
            job_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state <= ST_BUSY;
                            busy  <= 1'b1;
                        end else begin
                            state   <= ST_FINISH;
                            done    <= 1'b1;
                            aborted <= 1'b0;
`ifdef JOB_CTRL_STATS_EN
                            if (job_cnt != 16'hFFFF) job_cnt <= job_cnt + 16'd1;
`endif
                        end
                    end
                end
                ST_BUSY: begin
                    // abort takes precedence over natural completion
                    if (abort) begin
                        state   <= ST_FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (cnt_last) begin
                        state   <= ST_FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b0;
`ifdef JOB_CTRL_STATS_EN
                        if (job_cnt != 16'hFFFF) job_cnt <= job_cnt + 16'd1;
`endif
                    end
                end
                ST_FINISH: begin
                    if ((DONE_MODE == DONE_PULSE) || ack) begin
                        state   <= ST_IDLE;
                        done    <= 1'b0;
                        aborted <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    aborted <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_o = state;
    end

endmodule

// File: tb/tb_job_ctrl_fsm.sv
// Bench for job_ctrl_fsm: one instance per DONE_MODE on shared stimulus,
// a directed vector table, hand-written corner sequences and a random run
// checked against a cycle-level job model. Define JOB_CTRL_STATS_EN to
// also check job_cnt.
module tb_job_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst, start, abort, ack;
    logic [7:0] len;

    logic       busy0, done0, ab0, busy1, done1, ab1;
    logic [7:0] rem0, rem1;
    logic [1:0] st0, st1;
`ifdef JOB_CTRL_STATS_EN
    logic [15:0] jc0, jc1;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    job_ctrl_fsm #(.CNT_W(8), .DONE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .ack(ack),
        .busy(busy0), .done(done0), .aborted(ab0), .remaining(rem0), .state_o(st0)
`ifdef JOB_CTRL_STATS_EN
        , .job_cnt(jc0)
`endif
    );

    job_ctrl_fsm #(.CNT_W(8), .DONE_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .ack(ack),
        .busy(busy1), .done(done1), .aborted(ab1), .remaining(rem1), .state_o(st1)
`ifdef JOB_CTRL_STATS_EN
        , .job_cnt(jc1)
`endif
    );

    // ---------------- reference model ----------------
    // A job is described by how many busy cycles are left, whether we are
    // reporting completion, how it ended, and how many clean jobs finished.
    typedef struct {
        int left;
        bit fin;
        bit abt;
        int jobs;
    } mdl_t;

    mdl_t m0 = '{0, 0, 0, 0};
    mdl_t m1 = '{0, 0, 0, 0};

    function automatic mdl_t mstep(mdl_t m, bit hold, bit r, bit s, int l, bit a, bit k);
        mdl_t n = m;
        if (r) begin
            n = '{0, 0, 0, 0};
        end else if (m.fin) begin
            if (!hold || k) begin
                n.fin = 0;
                n.abt = 0;
            end
        end else if (m.left > 0) begin
            if (a) begin
                n.left = 0; n.fin = 1; n.abt = 1;
            end else begin
                n.left = m.left - 1;
                if (n.left == 0) begin
                    n.fin = 1; n.abt = 0;
                    if (n.jobs < 65535) n.jobs++;
                end
            end
        end else if (s) begin
            if (l == 0) begin
                n.fin = 1; n.abt = 0;
                if (n.jobs < 65535) n.jobs++;
            end else begin
                n.left = l;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 = mstep(m0, 1'b0, rst, start, int'(len), abort, ack);
        m1 = mstep(m1, 1'b1, rst, start, int'(len), abort, ack);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] mstate(mdl_t m);
        return (m.left > 0) ? 2'd1 : (m.fin ? 2'd2 : 2'd0);
    endfunction

    task automatic check_models();
        chk("m0_busy", 32'(busy0), 32'(m0.left > 0));
        chk("m0_done", 32'(done0), 32'(m0.fin));
        chk("m0_abt",  32'(ab0),   32'(m0.abt));
        chk("m0_rem",  32'(rem0),  32'(m0.left));
        chk("m0_st",   32'(st0),   32'(mstate(m0)));
        chk("m1_busy", 32'(busy1), 32'(m1.left > 0));
        chk("m1_done", 32'(done1), 32'(m1.fin));
        chk("m1_abt",  32'(ab1),   32'(m1.abt));
        chk("m1_rem",  32'(rem1),  32'(m1.left));
        chk("m1_st",   32'(st1),   32'(mstate(m1)));
`ifdef JOB_CTRL_STATS_EN
        chk("m0_jcnt", 32'(jc0), 32'(m0.jobs));
        chk("m1_jcnt", 32'(jc1), 32'(m1.jobs));
`endif
    endtask

    // apply inputs, clock once, sample 1 time unit after the edge
    task automatic cyc(input bit r, input bit s, input int l, input bit a, input bit k);
        rst = r; start = s; len = 8'(l); abort = a; ack = k;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed table (DONE_MODE=0 instance) ----------------
    typedef struct {
        bit       rst, start;
        int       len;
        bit       abort, ack;
        bit       busy, done, aborted;
        int       rem;
        int       st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit s, int l, bit a, bit k,
                                bit b, bit d, bit ab, int rm, int st);
        vec_t v;
        v.rst = r; v.start = s; v.len = l; v.abort = a; v.ack = k;
        v.busy = b; v.done = d; v.aborted = ab; v.rem = rm; v.st = st;
        return v;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; ack = 1'b0;

        //              rst s  len ab ak | busy done abt rem st
        vecs.push_back(mk(1, 0, 0,  0, 0,   0, 0, 0, 0,  0)); // reset
        vecs.push_back(mk(0, 1, 5,  0, 0,   1, 0, 0, 5,  1)); // len=5 start
        vecs.push_back(mk(0, 0, 0,  0, 0,   1, 0, 0, 4,  1));
        vecs.push_back(mk(0, 0, 0,  0, 0,   1, 0, 0, 3,  1));
        vecs.push_back(mk(0, 0, 0,  0, 0,   1, 0, 0, 2,  1));
        vecs.push_back(mk(0, 0, 0,  0, 0,   1, 0, 0, 1,  1));
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 1, 0, 0,  2)); // done at N+6
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 0,  0, 0,   0, 1, 0, 0,  2)); // len=0: done at N+1
        vecs.push_back(mk(0, 1, 3,  0, 0,   0, 0, 0, 0,  0)); // start in FINISH ignored
        vecs.push_back(mk(0, 1, 10, 0, 0,   1, 0, 0, 10, 1)); // len=10
        vecs.push_back(mk(0, 0, 0,  0, 0,   1, 0, 0, 9,  1));
        vecs.push_back(mk(0, 0, 0,  0, 0,   1, 0, 0, 8,  1)); // 3rd busy cycle
        vecs.push_back(mk(0, 0, 0,  1, 0,   0, 1, 1, 0,  2)); // abort
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 1,  0, 0,   1, 0, 0, 1,  1)); // len=1
        vecs.push_back(mk(0, 0, 0,  1, 0,   0, 1, 1, 0,  2)); // abort on last cycle wins
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 2,  0, 0,   1, 0, 0, 2,  1)); // len=2
        vecs.push_back(mk(0, 1, 4,  0, 0,   1, 0, 0, 1,  1)); // restart ignored
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 1, 0, 0,  2));
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 9,  0, 0,   1, 0, 0, 9,  1)); // len=9
        vecs.push_back(mk(0, 0, 0,  0, 0,   1, 0, 0, 8,  1));
        vecs.push_back(mk(0, 0, 0,  0, 0,   1, 0, 0, 7,  1));
        vecs.push_back(mk(1, 0, 0,  0, 0,   0, 0, 0, 0,  0)); // rst mid-BUSY
        vecs.push_back(mk(0, 1, 0,  0, 0,   0, 1, 0, 0,  2)); // to FINISH
        vecs.push_back(mk(1, 1, 6,  1, 1,   0, 0, 0, 0,  0)); // rst in FINISH wins

        #1;
        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].start, vecs[i].len, vecs[i].abort, vecs[i].ack);
            chk($sformatf("v%0d_busy", i), 32'(busy0), 32'(vecs[i].busy));
            chk($sformatf("v%0d_done", i), 32'(done0), 32'(vecs[i].done));
            chk($sformatf("v%0d_abt", i),  32'(ab0),   32'(vecs[i].aborted));
            chk($sformatf("v%0d_rem", i),  32'(rem0),  32'(vecs[i].rem));
            chk($sformatf("v%0d_st", i),   32'(st0),   32'(vecs[i].st));
            check_models();
        end
`ifdef JOB_CTRL_STATS_EN
        chk("jcnt_after_rst", 32'(jc0), 32'd0);
        cyc(0, 1, 0, 0, 0);
        chk("jcnt_len0", 32'(jc0), 32'd1);
        cyc(0, 0, 0, 0, 0);
`endif

        // ---- DONE_MODE=1: done held until ack, start ignored with ack ----
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0);
        chk("h_busy_first", 32'(busy1), 32'd1);
        chk("h_rem3", 32'(rem1), 32'd3);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("h_done_entry", 32'(done1), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk($sformatf("h_done_held%0d", i), 32'(done1), 32'd1);
            chk($sformatf("h_st_held%0d", i), 32'(st1), 32'd2);
            check_models();
        end
        cyc(0, 1, 5, 0, 1);
        chk("h_ack_idle", 32'(st1), 32'd0);
        chk("h_ack_busy", 32'(busy1), 32'd0);
        chk("h_ack_done", 32'(done1), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("h_start_ignored", 32'(busy1), 32'd0);
        check_models();

        // ---- DONE_MODE=1: aborted stays high throughout FINISH ----
        cyc(0, 1, 6, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("h_abt_hold%0d", i), 32'(ab1), 32'd1);
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 1);
        chk("h_abt_clear", 32'(ab1), 32'd0);
        check_models();

        // ---- randomized run against the model ----
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 2) == 0));
            check_models();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/job_ctrl_fsm.md
Name: job_ctrl_fsm

Overview:
- Parametrised successor to the team's start/busy/done controller.
- Runs one job of programmable length, counting cycles down from a value latched at start.
- Supports abort, and a choice between a one-cycle done pulse and a done held until acknowledged.
- Sits between a command source (start/len) and a consumer that watches busy/done or acknowledges completion.

Parameters:
- CNT_W, 8: width of len and remaining; max job length 2^CNT_W-1 cycles.
- DONE_MODE, 0: 0 = done is a one-cycle pulse, then IDLE; 1 = done is held in FINISH until ack.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  CNT_W  job length in cycles; latched together with start.
- abort  in  1  terminate the running job; sampled only in BUSY.
- ack  in  1  completion acknowledge; used only when DONE_MODE=1, sampled only in FINISH.
- busy  out  1  high while in BUSY.
- done  out  1  high while in FINISH.
- aborted  out  1  high in FINISH when the job ended via abort.
- remaining  out  CNT_W  cycles left in the current job; 0 outside BUSY.
- state_o  out  2  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=2'b00, BUSY=2'b01, FINISH=2'b10. 2'b11 is illegal and returns to IDLE on the next edge with all outputs at 0.
- Reset: rst=1 at a clock edge forces IDLE, remaining=0, and busy=done=aborted=0.
  - Reset overrides every other input, including mid-job and mid-FINISH.
  - No output may change before the clock edge.
- IDLE:
  - start=1 and len!=0 -> BUSY; remaining<=len.
  - start=1 and len==0 -> FINISH directly; aborted=0.
  - start=0 -> stay in IDLE.
- BUSY:
  - remaining decrements by 1 each cycle.
  - When remaining==1 the next state is FINISH with aborted=0, so busy is high for exactly len cycles.
  - start is ignored.
- Abort: abort=1 in BUSY -> FINISH on the next edge with aborted=1 and remaining<=0.
  - Abort wins over natural completion in the same cycle (remaining==1 and abort=1 gives aborted=1).
- Latency: start sampled at edge N -> busy asserted cycles N+1 .. N+len -> done asserted at cycle N+len+1. With len==0, done is asserted at N+1.
- FINISH, DONE_MODE=0: exactly one cycle, then IDLE. start during FINISH is ignored, not queued.
- FINISH, DONE_MODE=1: held until ack=1, then IDLE on the next edge.
  - start is ignored while in FINISH, including the cycle in which ack=1.
  - aborted holds its value for the whole FINISH.
- aborted clears on leaving FINISH.
- Arithmetic: remaining is unsigned CNT_W bits and never wraps, because decrement is only applied when remaining>=1.

Optional Feature:
- Macro: JOB_CTRL_STATS_EN.
- Defined:
  - Adds output job_cnt [15:0]: count of jobs completed without abort, including len==0 jobs.
  - Increments on entry to FINISH with aborted=0.
  - Saturates at 16'hFFFF; cleared only by rst.
- Undefined: job_cnt port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package job_ctrl_pkg: state encodings ST_IDLE, ST_BUSY, ST_FINISH; state width constant; DONE_PULSE/DONE_HOLD constants for DONE_MODE.
- One sub-module, job_len_counter (CNT_W):
  - Inputs: load, load value, dec, clear.
  - Outputs: remaining, last (remaining==1).
  - The FSM stays in the top level.

Test Plan:
- Reset then start=1, len=5 (DONE_MODE=0) -> busy high 5 cycles, remaining 5,4,3,2,1; done high 1 cycle at N+6; back to IDLE; aborted=0.
- start=1, len=0 -> done at N+1 with no busy cycle; with STATS_EN, job_cnt goes 0->1.
- len=10, abort asserted on the 3rd busy cycle -> FINISH next edge, aborted=1, remaining=0, done=1; job_cnt unchanged.
- DONE_MODE=1, len=3, ack held low 4 cycles, then ack=1 together with start=1 -> done held until ack, IDLE next edge, start ignored (busy stays 0).
- Abort and remaining==1 in the same cycle -> aborted=1; restart with start=1, len=4 while BUSY -> ignored, job length unchanged.
- rst=1 mid-BUSY (remaining=7) -> next edge state_o=00, remaining=0, all flags 0; with STATS_EN, job_cnt=0; rst=1 in FINISH gives the same result.
